serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Bit-serial subtractor: the subtraction counterpart of the team's ripple adders. It computes ip1 - ip2 - b_in one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. A start/done handshake wraps the operation. It is the area-minimal subtract path for the ALU datapath, where latency is acceptable.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk while busy=0
ip1  input  WIDTH  minuend; captured when start is accepted
ip2  input  WIDTH  subtrahend; captured when start is accepted
b_in  input  1  borrow-in; captured when start is accepted
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; diff and b_out are valid
diff  output  WIDTH  result ip1 - ip2 - b_in, modulo 2^WIDTH
b_out  output  1  final borrow-out (1 when ip1 < ip2 + b_in, unsigned)

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE; busy=0, done=0, diff=0, b_out=0.
  - Operand shift registers, borrow flop and bit counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - On start=1: latch ip1, ip2 into shift registers A, B; load borrow flop br=b_in; counter=0; go to SHIFT.
- SHIFT (busy=1), each clock:
  - a=A[0], b=B[0].
  - d = a^b^br.
  - br <= (~a&b) | (~(a^b)&br).
  - A, B shift right by 1.
  - Result register R shifts right, with d inserted at R[WIDTH-1].
  - counter increments.
  - When counter reaches WIDTH-1 on this clock: go to DONE.
- DONE (busy=0, done=1 for exactly one cycle):
  - diff=R, b_out=br.
  - Next clock goes to IDLE; if start=1 on that clock, a new operation is accepted instead (back-to-back, go to SHIFT).
- Latency: start accepted at edge k → SHIFT processes edges k+1..k+WIDTH → done high during the cycle after edge k+WIDTH.
- Throughput: one result per WIDTH+1 cycles.
- diff and b_out update only on entry to DONE and hold until the next DONE or reset. They are never exposed mid-operation.
- start while busy=1 is ignored; operands in flight are unaffected.
- Input changes on ip1/ip2/b_in after acceptance have no effect.
- Counter width is clog2(WIDTH); no wrap occurs beyond WIDTH-1.
- Reset asserted mid-SHIFT aborts immediately. No done pulse; outputs return to reset values.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), two's-complement signed overflow.
  - ovf = (ip1[MSB] != ip2[MSB]) && (diff[MSB] != ip1[MSB]), computed on the final bit cycle.
  - Equivalently, ovf = borrow into the MSB XOR borrow out of the MSB.
  - ovf is registered with diff, valid with done, reset to 0, and held like diff.
- When undefined:
  - No ovf port and no extra logic.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, reset then start with ip1=0x35, ip2=0x12, b_in=0 → done exactly 9 cycles after the accept edge; diff=0x23, b_out=0; busy high for 8 cycles.
- ip1=0x00, ip2=0x01, b_in=0 → diff=0xFF, b_out=1; with SERIAL_SUB_OVF_EN, ovf=0.
- ip1=0x10, ip2=0x0F, b_in=1 → diff=0x00, b_out=0. Then ip1=0x05, ip2=0x05, b_in=1 → diff=0xFF, b_out=1.
- With SERIAL_SUB_OVF_EN: ip1=0x80, ip2=0x01 → diff=0x7F, ovf=1, b_out=0. Then ip1=0x7F, ip2=0xFF → diff=0x80, ovf=1, b_out=1.
- Start 0x35-0x12; pulse start with 0xAA-0x01 at cycle 3 while busy → ignored; result is 0x23. Start asserted during the done cycle with 0x09-0x03 → accepted; next done gives diff=0x06.
- Start 0x35-0x12; assert rst_n=0 at cycle 4 for 2 cycles → busy=0, done never pulses, diff=0. A subsequent 0x35-0x12 completes normally with diff=0x23.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = ip1 - ip2 - b_in, one bit per clock, LSB first; optional ovf port when SERIAL_SUB_OVF_EN is defined.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+WIDTH; one result per WIDTH+1 cycles.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted back-to-back.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ip1,
    input  logic [WIDTH-1:0] ip2,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    // The minuend register doubles as the result register: each cycle its
    // consumed LSB falls off and the new difference bit enters at the MSB.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic br_nxt;
    logic accept;

    // Full-subtractor cell on the current LSBs and the borrow flop.
    always_comb begin
        a_bit  = a_q[0];
        b_bit  = b_q[0];
        d_bit  = a_bit ^ b_bit ^ br_q;
        br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    end

    // Next-state, datapath and result-capture logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        b_out_d = b_out_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        accept  = start && (state_q != SHIFT);

        case (state_q)
            SHIFT: begin
                a_d   = {d_bit, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = br_nxt;
                if (cnt_q == LAST_BIT) begin
                    // Final bit: publish the result; counter stays put rather than wrapping.
                    state_d = DONE;
                    diff_d  = {d_bit, a_q[WIDTH-1:1]};
                    b_out_d = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                    // Signed overflow is borrow into the MSB xor borrow out of it.
                    ovf_d   = br_q ^ br_nxt;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Operand load from IDLE or straight out of DONE.
        if (accept) begin
            state_d = SHIFT;
            a_d     = ip1;
            b_d     = ip2;
            br_d    = b_in;
            cnt_d   = '0;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            b_out_q <= b_out_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Overflow flag, captured and held alongside diff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);
    assign diff  = diff_q;
    assign b_out = b_out_q;

endmodule
